// File: rtl/chan_mux_scan_if.sv
// Channel mux bus: packed channel inputs, mode controls and the registered
// output word with its channel tag.
interface chan_mux_scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      scan_en;
  logic                      hold;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          dout_ch;
  logic                      dout_valid;
  logic                      wrap;

  modport master (
    output din, sel, scan_en, hold,
    input  dout, dout_ch, dout_valid, wrap
  );

  modport slave (
    input  din, sel, scan_en, hold,
    output dout, dout_ch, dout_valid, wrap
  );
endinterface

// File: rtl/chan_mux_scan.sv
// N-channel registered mux: MANUAL routes sel, SCAN walks the channels holding
// each for DWELL clocks, pulsing wrap on the first channel-0 word after the last.
//
// state  | meaning
// MANUAL | output follows sel; cnt and ptr held at 0
// SCAN   | output follows ptr; cnt/ptr advance unless hold
module chan_mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic           clk,
  input  logic           reset,
  chan_mux_scan_if.slave bus
);
  localparam int CNT_W = $clog2(DWELL) + 1;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_cur;
  logic [SEL_W-1:0] ptr, ptr_n, ptr_cur;
  logic [WIDTH-1:0] sel_word, ptr_word, dout_n;
  logic [SEL_W-1:0] dout_ch_n;
  logic             sel_ok, dout_valid_n, wrap_n;

  // The edge that enters SCAN already counts as channel 0's first dwell cycle.
  always_comb begin
    cnt_cur = (state == SCAN) ? cnt : '0;
    ptr_cur = (state == SCAN) ? ptr : '0;
  end

  always_comb begin
    sel_word = '0;
    ptr_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_word = bus.din[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
      if (ptr_cur == SEL_W'(k)) ptr_word = bus.din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n = bus.scan_en ? SCAN : MANUAL;
  end

  always_comb begin
    cnt_n        = '0;
    ptr_n        = '0;
    dout_n       = sel_word;
    dout_ch_n    = bus.sel;
    dout_valid_n = sel_ok;
    wrap_n       = 1'b0;
    if (state_n == SCAN) begin
      dout_n       = ptr_word;
      dout_ch_n    = ptr_cur;
      dout_valid_n = 1'b1;
      // ptr only drops from the last channel to 0 by wrapping, so this marks
      // the first word of channel 0 after a wrap.
      wrap_n       = (state == SCAN) && (ptr == '0) &&
                     (bus.dout_ch == SEL_W'(CHANNELS-1));
      cnt_n        = cnt_cur;
      ptr_n        = ptr_cur;
      if (!bus.hold) begin
        if (cnt_cur == CNT_W'(DWELL-1)) begin
          cnt_n = '0;
          ptr_n = (ptr_cur == SEL_W'(CHANNELS-1)) ? '0 : ptr_cur + 1'b1;
        end else begin
          cnt_n = cnt_cur + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= MANUAL;
      cnt            <= '0;
      ptr            <= '0;
      bus.dout       <= '0;
      bus.dout_ch    <= '0;
      bus.dout_valid <= 1'b0;
      bus.wrap       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      ptr            <= ptr_n;
      bus.dout       <= dout_n;
      bus.dout_ch    <= dout_ch_n;
      bus.dout_valid <= dout_valid_n;
      bus.wrap       <= wrap_n;
    end
  end
endmodule
